// File: rtl/cache_refill_ctrl_pkg.sv
// Shared constants and types for the cache line refill controller.
// Line geometry, bus widths and the refill FSM state encoding.
package cache_pkg;

  parameter int unsigned ADDR_W     = 22;
  parameter int unsigned DATA_W     = 8;
  parameter int unsigned OFF_W      = 2;
  parameter int unsigned LINE_BYTES = 1 << OFF_W;
  // Read-latency counter width; covers MEM_LAT up to 15.
  parameter int unsigned LAT_W      = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// CPU request, memory read and cache fill signals of the refill controller.
// master = CPU/memory/cache environment, slave = the controller itself.
interface cache_refill_ctrl_if #(
  parameter int unsigned ADDR_W = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W = cache_pkg::DATA_W
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              cache_hit;
  logic              req_ready;
  logic              mem_cs_n;
  logic              mem_oe_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              fill_done;
  logic              busy;

  modport master (
    output req_valid, req_addr, cache_hit, mem_data,
    input  req_ready, mem_cs_n, mem_oe_n, mem_addr,
    input  fill_we, fill_addr, fill_data, fill_done, busy
  );

  modport slave (
    input  req_valid, req_addr, cache_hit, mem_data,
    output req_ready, mem_cs_n, mem_oe_n, mem_addr,
    output fill_we, fill_addr, fill_data, fill_done, busy
  );

endinterface

// File: rtl/cache_refill_ctrl_lat_cnt.sv
// Memory read-latency counter: loads MEM_LAT, counts down once per read cycle,
// and flags the decrement that empties it (the last cycle of a read window).
module refill_lat_cnt #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = cache_pkg::LAT_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(MEM_LAT);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign zero_o = dec_i && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: on a miss, reads the line byte by byte from memory and writes it
// into the cache. Define REFILL_CRITICAL_FIRST_EN to start the fill at the requested byte.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_W  = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W  = cache_pkg::DATA_W,
  parameter int unsigned OFF_W   = cache_pkg::OFF_W,
  parameter int unsigned MEM_LAT = 2
) (
  input logic                clk,
  input logic                rst_n,
  cache_refill_ctrl_if.slave bus
);

  import cache_pkg::*;

  localparam int unsigned TagW = ADDR_W - OFF_W;
  localparam int unsigned CntW = OFF_W + 1;
  localparam logic [CntW-1:0] LineCnt = CntW'(LINE_BYTES);

  refill_state_e     state_q, state_d;
  logic [TagW-1:0]   tag_q, tag_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [CntW-1:0]   left_q, left_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [OFF_W-1:0]  start_off;
  logic [ADDR_W-1:0] cur_addr;
  logic              lat_load;
  logic              lat_dec;
  logic              lat_zero;

`ifdef REFILL_CRITICAL_FIRST_EN
  assign start_off = bus.req_addr[OFF_W-1:0];
`else
  assign start_off = '0;
`endif

  // Offset wraps within OFF_W bits, so the tag/index part never changes mid-line.
  assign cur_addr = {tag_q, off_q};

  refill_lat_cnt #(
    .MEM_LAT(MEM_LAT),
    .CNT_W  (LAT_W)
  ) u_lat_cnt (
    .clk_i (clk),
    .rst_ni(rst_n),
    .load_i(lat_load),
    .dec_i (lat_dec),
    .zero_o(lat_zero)
  );

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    off_d    = off_q;
    left_d   = left_q;
    data_d   = data_q;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && !bus.cache_hit) begin
          tag_d    = bus.req_addr[ADDR_W-1:OFF_W];
          off_d    = start_off;
          left_d   = LineCnt;
          lat_load = 1'b1;
          state_d  = StRd;
        end
      end
      StRd: begin
        lat_dec = 1'b1;
        if (lat_zero) begin
          data_d  = bus.mem_data;
          state_d = StWr;
        end
      end
      StWr: begin
        off_d  = off_q + 1'b1;
        left_d = left_q - 1'b1;
        if (left_q != CntW'(1)) begin
          lat_load = 1'b1;
          state_d  = StRd;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.busy      = (state_q != StIdle);
    bus.mem_cs_n  = 1'b1;
    bus.mem_oe_n  = 1'b1;
    bus.mem_addr  = '0;
    bus.fill_we   = 1'b0;
    bus.fill_addr = '0;
    bus.fill_data = '0;
    bus.fill_done = (state_q == StDone);
    if (state_q == StRd) begin
      bus.mem_cs_n = 1'b0;
      bus.mem_oe_n = 1'b0;
      bus.mem_addr = cur_addr;
    end
    if (state_q == StWr) begin
      bus.fill_we   = 1'b1;
      bus.fill_addr = cur_addr;
      bus.fill_data = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tag_q   <= '0;
      off_q   <= '0;
      left_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      off_q   <= off_d;
      left_q  <= left_d;
      data_q  <= data_d;
    end
  end

endmodule
